// File: rtl/dl_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : dl_decode_queue
//  Brief    : DLFloat16 instruction decoder followed by a small FIFO of
//             decoded entries (ready/valid on both sides, flush, 1-cycle
//             latency from push to head).
//  Revision : 1.0  initial release
// ============================================================================
module dl_decode_queue #(
   parameter int       DEPTH   = 4,
   parameter bit [6:0] OPC_FP  = 7'b1011011,
   parameter bit [6:0] OPC_FMA = 7'b1000011,
   parameter bit [6:0] OPC_FMS = 7'b1000111
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              instr,
   input  logic                     in_valid,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [3:0]               ena,
   output logic [2:0]               rm,
   output logic [1:0]               sel1,
   output logic [2:0]               sel2,
   output logic                     op,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_EW = 14;   // ena(4) rm(3) sel1(2) sel2(3) op(1) illegal(1)

   // fun5 codes of the FP opcode space
   localparam logic [4:0] c_F_ADD  = 5'b00000;
   localparam logic [4:0] c_F_SUB  = 5'b00001;
   localparam logic [4:0] c_F_MUL  = 5'b00010;
   localparam logic [4:0] c_F_DIV  = 5'b00011;
   localparam logic [4:0] c_F_SQRT = 5'b01011;
   localparam logic [4:0] c_F_CVA  = 5'b01000;
   localparam logic [4:0] c_F_CVB  = 5'b01001;
   localparam logic [4:0] c_F_CMP  = 5'b00100;
   localparam logic [4:0] c_F_MM   = 5'b00101;
   localparam logic [4:0] c_F_CLS  = 5'b10100;

   localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   logic [4:0] w_fun5;
   logic [2:0] w_rm;
   logic [6:0] w_opc;
   logic [3:0] w_ena;
   logic [1:0] w_sel1;
   logic [2:0] w_sel2;
   logic       w_op;
   logic       w_ill;
   logic       w_unused_bits;

   assign w_fun5        = instr[31:27];
   assign w_rm          = instr[14:12];
   assign w_opc         = instr[6:0];
   // Register-address fields play no part in unit selection
   assign w_unused_bits = ^{instr[26:15], instr[11:7]};

   // Combinational decode of the incoming word; anything unmatched is illegal
   always_comb begin
      w_ena  = 4'd0;
      w_sel1 = 2'b00;
      w_sel2 = 3'b000;
      w_op   = 1'b0;
      w_ill  = 1'b0;
      if (w_opc == OPC_FMA) begin
         w_ena = 4'd9;
      end else if (w_opc == OPC_FMS) begin
         w_ena = 4'd9;
         w_op  = 1'b1;
      end else if (w_opc == OPC_FP) begin
         case (w_fun5)
            c_F_ADD:  w_ena = 4'd1;
            c_F_SUB:  begin w_ena = 4'd1; w_op = 1'b1; end
            c_F_MUL:  w_ena = 4'd2;
            c_F_DIV:  w_ena = 4'd3;
            c_F_SQRT: w_ena = 4'd4;
            c_F_CVA:  w_ena = 4'd7;
            c_F_CVB:  w_ena = 4'd8;
            c_F_CMP: begin
               case (w_rm)
                  3'b000:  begin w_ena = 4'd5; w_sel1 = 2'b01; end
                  3'b001:  begin w_ena = 4'd5; w_sel1 = 2'b10; end
                  3'b010:  begin w_ena = 4'd5; w_sel1 = 2'b11; end
                  default: w_ill = 1'b1;
               endcase
            end
            c_F_MM: begin
               case (w_rm)
                  3'b000:  begin w_ena = 4'd6; w_sel2 = 3'b001; end
                  3'b001:  begin w_ena = 4'd6; w_sel2 = 3'b010; end
                  default: w_ill = 1'b1;
               endcase
            end
            c_F_CLS: begin
               case (w_rm)
                  3'b010:  begin w_ena = 4'd6; w_sel2 = 3'b011; end
                  3'b001:  begin w_ena = 4'd6; w_sel2 = 3'b100; end
                  3'b000:  begin w_ena = 4'd6; w_sel2 = 3'b101; end
                  default: w_ill = 1'b1;
               endcase
            end
            default: w_ill = 1'b1;
         endcase
      end else begin
         w_ill = 1'b1;
      end
   end

   logic [c_EW-1:0] w_entry;
   assign w_entry = {w_ena, w_rm, w_sel1, w_sel2, w_op, w_ill};

   // ------------------------------------------------------------------------
   // Queue
   // ------------------------------------------------------------------------
   logic [c_EW-1:0] r_mem [0:DEPTH-1];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_CW-1:0] r_count;
   logic            w_push;
   logic            w_pop;
   logic [c_EW-1:0] w_head;

   // in_ready deliberately ignores out_ready: a full queue never takes a
   // word even if the head leaves in the same cycle.
   assign in_ready  = (r_count != c_FULL);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // Storage write; flush drops the push so nothing is written
   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // Pointer and occupancy bookkeeping; reset beats flush beats traffic
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_CW'(1);
         end
      end
   end

   // Head fields are forced to zero whenever the queue is empty
   assign w_head  = out_valid ? r_mem[r_rd_ptr] : '0;
   assign ena     = w_head[13:10];
   assign rm      = w_head[9:7];
   assign sel1    = w_head[6:5];
   assign sel2    = w_head[4:2];
   assign op      = w_head[1];
   assign illegal = w_head[0];
   assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dl_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dl_decode_queue
//  Brief    : Directed self-checking bench for dl_decode_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dl_decode_queue;

   localparam int       DEPTH = 4;
   localparam bit [6:0] FP    = 7'b1011011;
   localparam bit [6:0] FMA   = 7'b1000011;
   localparam bit [6:0] FMS   = 7'b1000111;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        in_valid;
   logic        out_ready;
   logic        flush;
   logic        in_ready;
   logic        out_valid;
   logic [3:0]  ena;
   logic [2:0]  rm;
   logic [1:0]  sel1;
   logic [2:0]  sel2;
   logic        op;
   logic        illegal;
   logic [2:0]  count;

   int tests_run;
   int tests_failed;

   dl_decode_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .instr     (instr),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .ena       (ena),
      .rm        (rm),
      .sel1      (sel1),
      .sel2      (sel2),
      .op        (op),
      .illegal   (illegal),
      .count     (count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [13:0] obs;
   assign obs = {ena, rm, sel1, sel2, op, illegal};

   function automatic logic [31:0] mk(input logic [4:0] f5, input logic [2:0] r, input logic [6:0] opc);
      return {f5, 7'd0, 5'd0, r, 5'd0, opc};
   endfunction

   function automatic logic [13:0] ex(input int e, input int r, input int s1, input int s2, input int o, input int il);
      return {4'(e), 3'(r), 2'(s1), 3'(s2), 1'(o), 1'(il)};
   endfunction

   // One edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      instr    = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || obs !== 14'd0) begin
         tests_failed++;
         $display("FAIL reset: valid=%b ready=%b count=%0d fields=%h, need 0/1/0/0", out_valid, in_ready, count, obs);
      end
   endtask

   task automatic test_latency();
      push(32'h0800005B);
      tests_run++;
      if (out_valid !== 1'b1 || obs !== ex(1, 0, 0, 0, 1, 0) || count !== 3'd1) begin
         tests_failed++;
         $display("FAIL latency: valid=%b fields=%h count=%0d, need 1/%h/1", out_valid, obs, count, ex(1, 0, 0, 0, 1, 0));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || obs !== 14'd0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL empty_zero: valid=%b fields=%h count=%0d, need 0/0/0", out_valid, obs, count);
      end
   endtask

   task automatic test_decode();
      logic [31:0] vi [17];
      logic [13:0] ve [17];
      vi[0]  = mk(5'b00000, 3'b011, FP);  ve[0]  = ex(1, 3, 0, 0, 0, 0);
      vi[1]  = mk(5'b00010, 3'b000, FP);  ve[1]  = ex(2, 0, 0, 0, 0, 0);
      vi[2]  = mk(5'b00011, 3'b001, FP);  ve[2]  = ex(3, 1, 0, 0, 0, 0);
      vi[3]  = mk(5'b01011, 3'b000, FP);  ve[3]  = ex(4, 0, 0, 0, 0, 0);
      vi[4]  = mk(5'b01000, 3'b000, FP);  ve[4]  = ex(7, 0, 0, 0, 0, 0);
      vi[5]  = mk(5'b01001, 3'b000, FP);  ve[5]  = ex(8, 0, 0, 0, 0, 0);
      vi[6]  = mk(5'b00100, 3'b000, FP);  ve[6]  = ex(5, 0, 1, 0, 0, 0);
      vi[7]  = mk(5'b00100, 3'b001, FP);  ve[7]  = ex(5, 1, 2, 0, 0, 0);
      vi[8]  = mk(5'b00100, 3'b010, FP);  ve[8]  = ex(5, 2, 3, 0, 0, 0);
      vi[9]  = mk(5'b00100, 3'b011, FP);  ve[9]  = ex(0, 3, 0, 0, 0, 1);
      vi[10] = mk(5'b00101, 3'b000, FP);  ve[10] = ex(6, 0, 0, 1, 0, 0);
      vi[11] = mk(5'b00101, 3'b001, FP);  ve[11] = ex(6, 1, 0, 2, 0, 0);
      vi[12] = mk(5'b10100, 3'b010, FP);  ve[12] = ex(6, 2, 0, 3, 0, 0);
      vi[13] = mk(5'b10100, 3'b001, FP);  ve[13] = ex(6, 1, 0, 4, 0, 0);
      vi[14] = mk(5'b10100, 3'b000, FP);  ve[14] = ex(6, 0, 0, 5, 0, 0);
      vi[15] = mk(5'b11111, 3'b111, FMA); ve[15] = ex(9, 7, 0, 0, 0, 0);
      vi[16] = mk(5'b11111, 3'b000, FP);  ve[16] = ex(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 17; i++) begin
         push(vi[i]);
         tests_run++;
         if (out_valid !== 1'b1 || obs !== ve[i]) begin
            tests_failed++;
            $display("FAIL decode[%0d]: valid=%b fields=%h, need 1/%h", i, out_valid, obs, ve[i]);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_full_drain();
      for (int i = 0; i < DEPTH; i++) push(mk(5'b00000, 3'(i), FP));
      tests_run++;
      if (in_ready !== 1'b0 || count !== 3'd4) begin
         tests_failed++;
         $display("FAIL full: ready=%b count=%0d, need 0/4", in_ready, count);
      end
      push(mk(5'b00010, 3'b111, FP));
      tests_run++;
      if (count !== 3'd4 || rm !== 3'd0) begin
         tests_failed++;
         $display("FAIL full_reject: count=%0d head_rm=%0d, need 4/0", count, rm);
      end
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tests_run++;
         if (out_valid !== 1'b1 || obs !== ex(1, i, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL drain[%0d]: valid=%b fields=%h, need 1/%h", i, out_valid, obs, ex(1, i, 0, 0, 0, 0));
         end
         tick();
      end
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL drain_end: valid=%b count=%0d, need 0/0", out_valid, count);
      end
   endtask

   // Full queue with both sides active; also walks pointers past the wrap
   task automatic test_back_to_back();
      int exp_cnt [6];
      int exp_rm  [6];
      for (int i = 0; i < DEPTH; i++) push(mk(5'b00000, 3'(i), FP));
      out_ready = 1'b1;
      in_valid  = 1'b1;
      instr     = mk(5'b00000, 3'd4, FP);
      tick();                     // full: pop only
      tests_run++;
      if (count !== 3'd3 || rm !== 3'd1) begin
         tests_failed++;
         $display("FAIL b2b_full_pop: count=%0d head_rm=%0d, need 3/1", count, rm);
      end
      tick();                     // rm4 accepted, rm1 leaves
      tests_run++;
      if (count !== 3'd3 || rm !== 3'd2) begin
         tests_failed++;
         $display("FAIL b2b_swap1: count=%0d head_rm=%0d, need 3/2", count, rm);
      end
      instr = mk(5'b00000, 3'd5, FP);
      tick();                     // rm5 accepted, rm2 leaves
      tests_run++;
      if (count !== 3'd3 || rm !== 3'd3) begin
         tests_failed++;
         $display("FAIL b2b_swap2: count=%0d head_rm=%0d, need 3/3", count, rm);
      end
      in_valid = 1'b0;
      exp_cnt[0] = 2; exp_rm[0] = 4;
      exp_cnt[1] = 1; exp_rm[1] = 5;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (count !== 3'(exp_cnt[i]) || rm !== 3'(exp_rm[i]) || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_tail[%0d]: count=%0d rm=%0d valid=%b, need %0d/%0d/1", i, count, rm, out_valid, exp_cnt[i], exp_rm[i]);
         end
      end
      tick();
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL b2b_empty: valid=%b count=%0d, need 0/0", out_valid, count);
      end
   endtask

   task automatic test_illegal();
      logic [13:0] e [3];
      e[0] = ex(0, 3, 0, 0, 0, 1);
      e[1] = ex(0, 0, 0, 0, 0, 1);
      e[2] = ex(9, 2, 0, 0, 1, 0);
      push(mk(5'b00101, 3'b011, FP));
      push(mk(5'b00000, 3'b000, 7'h33));
      push(mk(5'b01010, 3'b010, FMS));
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (out_valid !== 1'b1 || obs !== e[i]) begin
            tests_failed++;
            $display("FAIL illegal[%0d]: valid=%b fields=%h, need 1/%h", i, out_valid, obs, e[i]);
         end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push(mk(5'b00010, 3'(i), FP));
      flush     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      instr     = mk(5'b00011, 3'b000, FP);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests_run++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 14'd0) begin
         tests_failed++;
         $display("FAIL flush: count=%0d valid=%b ready=%b fields=%h, need 0/0/1/0", count, out_valid, in_ready, obs);
      end
      push(mk(5'b01000, 3'b000, FP));
      tests_run++;
      if (count !== 3'd1 || ena !== 4'd7) begin
         tests_failed++;
         $display("FAIL flush_restart: count=%0d ena=%0d, need 1/7", count, ena);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      push(mk(5'b00010, 3'b001, FP));
      push(mk(5'b00011, 3'b010, FP));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests_run++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 14'd0) begin
         tests_failed++;
         $display("FAIL mid_reset: count=%0d valid=%b ready=%b fields=%h, need 0/0/1/0", count, out_valid, in_ready, obs);
      end
      push(mk(5'b01001, 3'b000, FP));
      tests_run++;
      if (count !== 3'd1 || ena !== 4'd8) begin
         tests_failed++;
         $display("FAIL post_reset_head: count=%0d ena=%0d, need 1/8", count, ena);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      instr        = '0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      flush        = 1'b0;
      test_reset();
      test_latency();
      test_decode();
      test_full_drain();
      test_back_to_back();
      test_illegal();
      test_flush();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dl_decode_queue.md
DL_DECODE_QUEUE -- requirements
Module: dl_decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning decoded-entry queue depth (power of 2, minimum 2).
REQ-002 The block SHALL have parameter OPC_FP, default 7'b1011011, meaning the DLFloat16 arithmetic opcode.
REQ-003 The block SHALL have parameter OPC_FMA, default 7'b1000011, meaning the fused multiply-add opcode.
REQ-004 The block SHALL have parameter OPC_FMS, default 7'b1000111, meaning the fused multiply-subtract opcode.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows: clk in 1 (system clock, rising edge); rst_n in 1 (reset, synchronous, active-low).
REQ-006 The block SHALL have the following input ports: instr in 32 (instruction word); in_valid in 1 (instr valid); out_ready in 1 (consumer accepts head entry); flush in 1 (discard all queued entries).
REQ-007 The block SHALL have the following output ports: in_ready out 1 (queue can accept); out_valid out 1 (head entry valid); ena out 4 (unit select); rm out 3 (rounding mode); sel1 out 2 (compare select); sel2 out 3 (min/max/classify select); op out 1 (add/sub or fma/fms); illegal out 1 (undecodable instruction); count out $clog2(DEPTH)+1 (entries held).

Function
REQ-008 The block SHALL set fun5 = instr[31:27] and rm = instr[14:12] when decoding.
REQ-009 For OPC_FP, the block SHALL decode as follows: fun5 00000 -> ena 1, op 0; 00001 -> ena 1, op 1; 00010 -> ena 2; 00011 -> ena 3; 01011 -> ena 4; 01000 -> ena 7; 01001 -> ena 8.
REQ-010 For OPC_FP with fun5 00100, the block SHALL decode rm 000/001/010 to ena 5 with sel1 01/10/11 respectively.
REQ-011 For OPC_FP with fun5 00101, the block SHALL decode rm 000 -> ena 6, sel2 001 (min) and rm 001 -> ena 6, sel2 010 (max).
REQ-012 For OPC_FP with fun5 10100, the block SHALL decode rm 010/001/000 to ena 6 with sel2 011/100/101 respectively.
REQ-013 The block SHALL decode OPC_FMA to ena 9, op 0 and OPC_FMS to ena 9, op 1, for any fun5 and rm.
REQ-014 Any other opcode, fun5, or rm combination SHALL decode to illegal=1, ena 0, op 0, sel1 0, sel2 0; such an entry SHALL still be queued.
REQ-015 Fields not set by a decode row SHALL be 0; rm SHALL always carry instr[14:12].
REQ-016 A push SHALL occur when in_valid and in_ready are both 1 at a rising edge; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL be (count != DEPTH); it SHALL not depend combinationally on out_ready, so a full queue does not accept an input even when a pop occurs in the same cycle.
REQ-018 out_valid SHALL be (count != 0); the output fields SHALL be driven from the head entry, which SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-019 Latency SHALL be 1 cycle: an instruction pushed into an empty queue SHALL appear at the outputs with out_valid=1 on the next cycle.
REQ-020 A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and SHALL preserve order.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; entries SHALL emerge in strict FIFO order.
REQ-022 When out_valid=0, the output fields SHALL be 0.
REQ-023 When flush=1 at an edge, the queue SHALL empty (count 0, pointers 0), and any push or pop in that cycle SHALL be ignored.
REQ-024 flush SHALL have lower priority than reset.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL clear pointers and count to 0, so that out_valid=0, in_ready=1, and all output fields are 0 from the next cycle.
REQ-026 Reset asserted mid-stream SHALL discard all entries, and no entry accepted before reset SHALL be output after reset.

Verification
REQ-027 Push 32'h0800005B (FP, fun5 00001, rm 000) into an empty queue -> next cycle out_valid=1, ena=1, op=1, illegal=0, count=1.
REQ-028 Push DEPTH instructions with out_ready=0 -> in_ready=0 at count=DEPTH; a further push is not accepted; then drain with out_ready=1 -> DEPTH entries emerge in order and out_valid falls to 0.
REQ-029 Hold a full queue with in_valid=1 and out_ready=1 -> one pop per cycle with no push on the full cycles; count decrements to DEPTH-1, after which a push and a pop occur each cycle.
REQ-030 Push fun5 00101 with rm 011, then push opcode 7'h33 -> both entries give illegal=1, ena=0; FMS opcode -> ena=9, op=1.
REQ-031 Fill 3 entries, then assert flush with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the input was not queued.
REQ-032 Apply rst_n=0 for 1 cycle with 2 entries queued -> next cycle count=0, out_valid=0, in_ready=1, outputs 0.
